// File: rtl/pattern_merge_bist_pkg.sv
// Shared types and constants for the pattern-merge self-test controller:
// FSM state encoding, default widths/polynomials and the Galois LFSR step.
package pattern_merge_bist_pkg;

  localparam int          SIG_W_DEF     = 16;
  localparam logic [15:0] LFSR_SEED_DEF = 16'h0001;
  localparam logic [15:0] LFSR_POLY_DEF = 16'hB400;
  localparam logic [15:0] MISR_POLY_DEF = 16'hB400;

  // Wide enough for any SIG_W up to 32; a right shift never pulls upper
  // zero-extension bits down, so truncating the result back is exact.
  localparam int GALOIS_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    REPORT
  } state_t;

  function automatic logic [GALOIS_W-1:0] galois_step(input logic [GALOIS_W-1:0] val,
                                                      input logic [GALOIS_W-1:0] poly);
    return (val >> 1) ^ (val[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/pattern_misr.sv
// Multiple-input signature register: shift-left Galois compactor with a
// synchronous clear that takes priority over the capture enable.
module pattern_misr
  import pattern_merge_bist_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ data;
    end
  end

endmodule

// File: rtl/pattern_merge_bist_ctrl.sv
// Self-test driver/collector: LFSR stimulus into a generated netlist, MISR
// compaction of its outputs after a fixed latency, signature via valid/ready.
module pattern_merge_bist_ctrl
  import pattern_merge_bist_pkg::*;
#(
  parameter int               IN_W      = 11,
  parameter int               OUT_W     = 10,
  parameter int               SIG_W     = SIG_W_DEF,
  parameter int               CNT_W     = 16,
  parameter int               LAT       = 2,
  parameter logic [SIG_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter logic [SIG_W-1:0] LFSR_POLY = LFSR_POLY_DEF,
  parameter logic [SIG_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [CNT_W-1:0] pattern_count,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic [SIG_W-1:0] sig_data,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic             done
);

  // With no netlist latency the drain phase is skipped entirely.
  localparam state_t     AFTER_DRIVE = (LAT == 0) ? REPORT : FLUSH;
  localparam logic [2:0] FLUSH_LAST  = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SIG_W-1:0] lfsr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       flush_cnt;
  logic             drive_vld;
  logic             cap_vld;
  logic             run_start;
  logic [SIG_W-1:0] misr_sig;

  assign run_start = (state == IDLE) && start;

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the next-state value is defaulted before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (pattern_count != '0) ? RUN : AFTER_DRIVE;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = AFTER_DRIVE;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = REPORT;
      REPORT:  if (sig_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dut_in    = '0;
    busy      = 1'b0;
    sig_valid = 1'b0;
    sig_data  = '0;
    done      = 1'b0;
    drive_vld = 1'b0;
    case (state)
      RUN: begin
        drive_vld = 1'b1;
        dut_in    = lfsr[IN_W-1:0];
        busy      = 1'b1;
      end
      FLUSH: busy = 1'b1;
      REPORT: begin
        busy      = 1'b1;
        sig_valid = 1'b1;
        sig_data  = misr_sig;
        done      = sig_ready;
      end
      default: ;
    endcase
  end

  // The counter holds vectors still to drive, so it never needs to wrap.
  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      lfsr      <= LFSR_SEED;
      cnt       <= '0;
      flush_cnt <= '0;
    end else begin
      if (run_start) begin
        lfsr <= LFSR_SEED;
        cnt  <= pattern_count;
      end else if (state == RUN) begin
        lfsr <= SIG_W'(galois_step(GALOIS_W'(lfsr), GALOIS_W'(LFSR_POLY)));
        cnt  <= cnt - CNT_W'(1);
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 3'd1 : 3'd0;
    end
  end

  // Drive-valid delayed by the netlist latency marks which cycles to capture.
  if (LAT == 0) begin : g_no_pipe
    assign cap_vld = drive_vld;
  end else begin : g_pipe
    logic [LAT-1:0] vld_pipe;
    always_ff @(posedge blif_clk_net) begin
      if (!blif_reset_net) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe <= (vld_pipe << 1) | LAT'(drive_vld);
      end
    end
    assign cap_vld = vld_pipe[LAT-1];
  end

  pattern_misr #(
    .SIG_W (SIG_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (blif_clk_net),
    .rst_n (blif_reset_net),
    .clr   (run_start),
    .en    (cap_vld),
    .data  (SIG_W'(dut_out)),
    .sig   (misr_sig)
  );

endmodule

// File: tb/tb_pattern_merge_bist_ctrl.sv
// Directed + randomized bench for pattern_merge_bist_ctrl at LAT=2 and LAT=0,
// checked against a sequence-level LFSR/MISR reference model.
module tb_pattern_merge_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v   [2];
  logic [15:0] count_v   [2];
  logic [9:0]  dout_v    [2];
  logic        ready_v   [2];
  logic [10:0] din_v     [2];
  logic        busy_v    [2];
  logic [15:0] sigd_v    [2];
  logic        sigv_v    [2];
  logic        done_v    [2];

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] last_sig;
  logic [10:0] seen_in [$];

  always #5 clk = ~clk;

  pattern_merge_bist_ctrl #(.LAT(2)) u_lat2 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start_v[0]),
    .pattern_count  (count_v[0]),
    .dut_in         (din_v[0]),
    .dut_out        (dout_v[0]),
    .busy           (busy_v[0]),
    .sig_data       (sigd_v[0]),
    .sig_valid      (sigv_v[0]),
    .sig_ready      (ready_v[0]),
    .done           (done_v[0])
  );

  pattern_merge_bist_ctrl #(.LAT(0)) u_lat0 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start_v[1]),
    .pattern_count  (count_v[1]),
    .dut_in         (din_v[1]),
    .dut_out        (dout_v[1]),
    .busy           (busy_v[1]),
    .sig_data       (sigd_v[1]),
    .sig_valid      (sigv_v[1]),
    .sig_ready      (ready_v[1]),
    .done           (done_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // LFSR state after n steps from the seed.
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v = 16'h0001;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Signature of an ordered sequence of captured responses.
  function automatic logic [15:0] misr_of(input logic [9:0] q [$]);
    logic [15:0] m = 16'h0000;
    foreach (q[i]) m = (m << 1) ^ (m[15] ? 16'hB400 : 16'h0000) ^ {6'b0, q[i]};
    return m;
  endfunction

  function automatic logic [9:0] resp(input int mode, input int k);
    case (mode)
      1:       return 10'h001;
      2:       return 10'h000;
      3:       return 10'(k * 37 + 5);
      default: return 10'($urandom);
    endcase
  endfunction

  task automatic check_idle(input int s, input string tag);
    check({tag, "_busy"}, 32'(busy_v[s]), 32'd0);
    check({tag, "_valid"}, 32'(sigv_v[s]), 32'd0);
    check({tag, "_data"}, 32'(sigd_v[s]), 32'd0);
    check({tag, "_done"}, 32'(done_v[s]), 32'd0);
    check({tag, "_din"}, 32'(din_v[s]), 32'd0);
  endtask

  // One complete run on instance s: n vectors, response mode, stall cycles
  // of back-pressure (with ignored start pulses), then the handshake.
  task automatic run(input int s, input int n, input int mode, input int stall);
    int          lat;
    logic [9:0]  vals [$];
    logic [9:0]  dv;
    logic [15:0] exp_l;
    logic [15:0] exp_sig;
    lat = (s == 0) ? 2 : 0;
    seen_in.delete();
    @(negedge clk);
    start_v[s] = 1'b1;
    count_v[s] = 16'(n);
    @(negedge clk);
    start_v[s] = 1'b0;
    count_v[s] = 16'($urandom);
    for (int k = 1; k <= n + lat + 1; k++) begin
      if (k <= n) begin
        exp_l = lfsr_after(k - 1);
        check("dut_in_run", 32'(din_v[s]), {21'b0, exp_l[10:0]});
        seen_in.push_back(din_v[s]);
      end else begin
        check("dut_in_idle", 32'(din_v[s]), 32'd0);
      end
      check("busy_run", 32'(busy_v[s]), 32'd1);
      check("valid_timing", 32'(sigv_v[s]), (k == n + lat + 1) ? 32'd1 : 32'd0);
      dv = resp(mode, k);
      dout_v[s] = dv;
      if (k > lat && k <= lat + n) vals.push_back(dv);
      if (k <= n + lat) @(negedge clk);
    end
    exp_sig = misr_of(vals);
    check("sig_data", 32'(sigd_v[s]), {16'b0, exp_sig});
    last_sig = sigd_v[s];
    for (int r = 0; r < stall; r++) begin
      @(negedge clk);
      start_v[s] = 1'($urandom);
      count_v[s] = 16'($urandom);
      check("bp_valid", 32'(sigv_v[s]), 32'd1);
      check("bp_data", 32'(sigd_v[s]), {16'b0, exp_sig});
      check("bp_done", 32'(done_v[s]), 32'd0);
      check("bp_busy", 32'(busy_v[s]), 32'd1);
    end
    start_v[s] = 1'b0;
    ready_v[s] = 1'b1;
    #1;
    check("hs_done", 32'(done_v[s]), 32'd1);
    check("hs_valid", 32'(sigv_v[s]), 32'd1);
    @(negedge clk);
    ready_v[s] = 1'b0;
    check_idle(s, "post_hs");
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      count_v[s] = '0;
      dout_v[s]  = '0;
      ready_v[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_idle(0, "reset_lat2");
    check_idle(1, "reset_lat0");
    rst_n = 1'b1;

    // LFSR sequence and capture alignment with a constant response of 1.
    run(0, 3, 1, 0);
    check("lfsr_v0", 32'(seen_in[0]), 32'h001);
    check("lfsr_v1", 32'(seen_in[1]), 32'h400);
    check("lfsr_v2", 32'(seen_in[2]), 32'h200);
    check("sig_ones3", 32'(last_sig), 32'h0007);

    // Zero response, and zero-length runs with noisy responses.
    n = $urandom_range(1, 20);
    run(0, n, 2, 0);
    check("sig_zero_resp", 32'(last_sig), 32'h0000);
    run(0, 0, 0, 0);
    check("sig_count0_lat2", 32'(last_sig), 32'h0000);
    run(1, 0, 0, 0);
    check("sig_count0_lat0", 32'(last_sig), 32'h0000);

    // Back-pressure for 10 cycles with start pulses that must be ignored.
    run(0, 4, 0, 10);

    // Reset after two of five vectors.
    @(negedge clk);
    start_v[0] = 1'b1;
    count_v[0] = 16'd5;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle(0, "mid_reset");
    rst_n = 1'b1;
    run(1, 1, 1, 0);
    check("sig_lat0_one", 32'(last_sig), 32'h0001);
    run(0, 5, 0, 1);

    // Back-to-back identical stimulus.
    run(0, 7, 3, 2);
    run(0, 7, 3, 0);

    // Randomized runs on both latencies.
    for (int i = 0; i < 10; i++) begin
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 30)), 0,
          int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
